// File: rtl/mat_result_streamer.sv
// mat_result_streamer
// Captures the packed 4x4 product matrix when the multiply path signals
// finish, then streams the 16 entries row-major over a valid/ready
// handshake, tagging each beat with row, column and last.
// Optional build macro: RESULT_CHECKSUM_EN adds chk_out, the running sum
// of all transferred entries (stable from the done cycle to next capture).
module mat_result_streamer #(
    parameter int ENTRY_W = 6,
    parameter int N       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N*N*ENTRY_W-1:0]   mat_in,
    input  logic                     finish,
    output logic [ENTRY_W-1:0]       out_data,
    output logic [$clog2(N)-1:0]     out_row,
    output logic [$clog2(N)-1:0]     out_col,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
`ifdef RESULT_CHECKSUM_EN
    output logic [9:0]               chk_out,
`endif
    output logic                     done
);

    localparam int NUM_E = N * N;
    localparam int TOT_W = NUM_E * ENTRY_W;
    localparam int RC_W  = $clog2(N);
    localparam int IDX_W = $clog2(NUM_E);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_CLR
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [TOT_W-1:0]     r_mat;
    logic [IDX_W-1:0]     r_index;
    logic                 r_done;

    logic                 w_send;
    logic                 w_xfer;
    logic                 w_last_idx;
    logic                 w_capture;
    logic [ENTRY_W-1:0]   w_entry [NUM_E];
    logic [ENTRY_W-1:0]   w_cur;

    // Entry k sits at the top of the packed word first (C[0][0] is the MSBs).
    genvar gi;
    generate
        for (gi = 0; gi < NUM_E; gi++) begin : g_unpack
            assign w_entry[gi] = r_mat[(NUM_E-1-gi)*ENTRY_W +: ENTRY_W];
        end
    endgenerate

    assign w_send     = (r_state == S_SEND);
    assign w_xfer     = w_send && out_ready;
    assign w_last_idx = (r_index == IDX_W'(NUM_E - 1));
    assign w_capture  = (r_state == S_IDLE) && finish;
    assign w_cur      = w_entry[r_index];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: finish is a held level, so WAIT_CLR blocks a
    // second stream until the multiply path drops it.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     if (finish) w_state_next = S_SEND;
            S_SEND:     if (w_xfer && w_last_idx) w_state_next = S_WAIT_CLR;
            S_WAIT_CLR: if (!finish) w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    // Capture register: snapshot taken once so later mat_in changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mat <= '0;
        end else if (w_capture) begin
            r_mat <= mat_in;
        end
    end

    // Beat index: restarts at capture, advances per transfer, saturates at the last entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_index <= '0;
        end else if (w_capture) begin
            r_index <= '0;
        end else if (w_xfer && !w_last_idx) begin
            r_index <= r_index + 1'b1;
        end
    end

    // Done pulse for the single cycle after the final beat transfers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_xfer && w_last_idx;
        end
    end

`ifdef RESULT_CHECKSUM_EN
    logic [9:0] r_chk;

    // Checksum accumulator: cleared at capture, adds each transferred entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chk <= '0;
        end else if (w_capture) begin
            r_chk <= '0;
        end else if (w_xfer) begin
            r_chk <= r_chk + 10'(w_cur);
        end
    end

    assign chk_out = r_chk;
`endif

    // Outputs come straight from registers; beat fields are zeroed outside SEND.
    assign out_valid = w_send;
    assign busy      = w_send;
    assign done      = r_done;
    assign out_data  = w_send ? w_cur : '0;
    assign out_row   = w_send ? r_index[IDX_W-1:RC_W] : '0;
    assign out_col   = w_send ? r_index[RC_W-1:0] : '0;
    assign out_last  = w_send && w_last_idx;

endmodule

// File: tb/tb_mat_result_streamer.sv
// Scoreboard bench for mat_result_streamer: stimulus pushes expected beats,
// a negedge monitor pops and compares on every transfer.
module tb_mat_result_streamer;

    typedef struct {
        logic [5:0] data;
        logic [1:0] row;
        logic [1:0] col;
        logic       last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [95:0] mat_in;
    logic        finish;
    logic [5:0]  out_data;
    logic [1:0]  out_row;
    logic [1:0]  out_col;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
`ifdef RESULT_CHECKSUM_EN
    logic [9:0]  chk_out;
    int          exp_chk_q[$];
`endif

    beat_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          n_xfer = 0;
    logic [5:0]  ramp [16];
    logic [5:0]  c36  [16];

    mat_result_streamer #(.ENTRY_W(6), .N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mat_in    (mat_in),
        .finish    (finish),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
`ifdef RESULT_CHECKSUM_EN
        .chk_out   (chk_out),
`endif
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [95:0] pack(input logic [5:0] v [16]);
        logic [95:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) r[95-6*k -: 6] = v[k];
        return r;
    endfunction

    // Present a matrix and queue the 16 beats it must produce.
    task automatic issue(input logic [5:0] v [16]);
        int    s;
        beat_t b;
        s = 0;
        mat_in = pack(v);
        for (int k = 0; k < 16; k++) begin
            b.data = v[k];
            b.row  = 2'(k / 4);
            b.col  = 2'(k % 4);
            b.last = (k == 15);
            exp_q.push_back(b);
            s += int'(v[k]);
        end
`ifdef RESULT_CHECKSUM_EN
        exp_chk_q.push_back(s);
`else
        if (s < 0) $display("negative sum");
`endif
    endtask

    task automatic wait_done(input string name, input int budget);
        int c;
        bit seen;
        c = 0;
        seen = 0;
        while (!seen && c < budget) begin
            @(negedge clk);
            c++;
            if (done) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: done not seen within %0d cycles", name, budget);
        end else begin
            check({name, "_busy_at_done"}, int'(busy), 0);
        end
    endtask

    // Monitor / scoreboard.
    bit         prev_stall = 0;
    bit         prev_last  = 0;
    logic [5:0] prev_data;
    logic [1:0] prev_row, prev_col;
    beat_t      e;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
            prev_last  = 0;
        end else begin
            if (done || prev_last) check("done_pulse", int'(done), int'(prev_last));
`ifdef RESULT_CHECKSUM_EN
            if (done) begin
                if (exp_chk_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL chk_out: no expected checksum, got %0d", chk_out);
                end else begin
                    check("chk_out", int'(chk_out), exp_chk_q.pop_front());
                end
            end
`endif
            if (out_valid || busy) check("busy_eq_valid", int'(busy), int'(out_valid));
            if (prev_stall && out_valid) begin
                check("stall_data", int'(out_data), int'(prev_data));
                check("stall_row", int'(out_row), int'(prev_row));
                check("stall_col", int'(out_col), int'(prev_col));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data=%0d, none expected", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", int'(out_data), int'(e.data));
                    check("beat_row", int'(out_row), int'(e.row));
                    check("beat_col", int'(out_col), int'(e.col));
                    check("beat_last", int'(out_last), int'(e.last));
                end
                n_xfer++;
                $display("beat %0d: data=%0d row=%0d col=%0d last=%0d",
                         n_xfer, out_data, out_row, out_col, out_last);
            end
            prev_last  = out_valid && out_ready && out_last;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_row   = out_row;
            prev_col   = out_col;
        end
    end

    int  base;
    bit  got;
    int  c;

    initial begin
        for (int k = 0; k < 16; k++) begin
            ramp[k] = 6'(k);
            c36[k]  = 6'd36;
        end
        rst = 1'b1;
        finish = 1'b0;
        out_ready = 1'b0;
        mat_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_last", int'(out_last), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_row", int'(out_row), 0);
        check("rst_col", int'(out_col), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic stream, ready held high, with one-cycle latency check.
        @(posedge clk); #1;
        base = n_xfer;
        issue(ramp);
        finish = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("latency_before", int'(out_valid), 0);
        @(negedge clk);
        check("latency_first", int'(out_valid), 1);
        wait_done("t1", 40);
        check("t1_count", n_xfer - base, 16);

        // Finish held for 60 more cycles: no second stream.
        base = n_xfer;
        repeat (60) @(negedge clk);
        check("hold_no_restream", n_xfer - base, 0);
        @(posedge clk); #1;
        finish = 1'b0;
        @(posedge clk); #1;
        base = n_xfer;
        issue(c36);
        finish = 1'b1;
        wait_done("t36", 40);
        check("t36_count", n_xfer - base, 16);

        // Backpressure pattern 1,0,0 repeating.
        @(posedge clk); #1;
        finish = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        base = n_xfer;
        issue(ramp);
        finish = 1'b1;
        got = 0;
        c = 0;
        while (!got && c < 200) begin
            out_ready = (c % 3 == 0);
            @(negedge clk);
            if (done) got = 1;
            @(posedge clk); #1;
            c++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL stall_done: done not seen within 200 cycles");
        end
        check("stall_count", n_xfer - base, 16);

        // mat_in cleared right after capture, finish dropped mid-stream.
        out_ready = 1'b1;
        finish = 1'b0;
        @(posedge clk); #1;
        base = n_xfer;
        issue(ramp);
        finish = 1'b1;
        @(posedge clk); #1;
        mat_in = '0;
        repeat (3) @(posedge clk);
        #1;
        finish = 1'b0;
        wait_done("t4", 40);
        check("t4_count", n_xfer - base, 16);

        // Reset during beat 7, then restart with finish held.
        @(posedge clk); #1;
        issue(ramp);
        finish = 1'b1;
        c = 0;
        while (!(out_valid && out_data == 6'd6) && c < 40) begin
            @(negedge clk);
            c++;
        end
        check("t5_reach_beat6", int'(out_valid && out_data == 6'd6), 1);
        @(posedge clk); #1;
        check("t5_beat7_present", int'(out_data), 7);
        rst = 1'b1;
        exp_q.delete();
`ifdef RESULT_CHECKSUM_EN
        exp_chk_q.delete();
`endif
        #1;
        check("t5_rst_valid", int'(out_valid), 0);
        check("t5_rst_busy", int'(busy), 0);
        check("t5_rst_done", int'(done), 0);
        @(posedge clk); #1;
        base = n_xfer;
        issue(ramp);
        rst = 1'b0;
        wait_done("t5", 40);
        check("t5_count", n_xfer - base, 16);
        check("final_queue_empty", exp_q.size(), 0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mat_result_streamer.md
Name: mat_result_streamer

Overview:
- Reader at the output end of the 4x4 matrix-multiply path.
- Captures the 96-bit packed product matrix when the multiply path asserts `finish`.
- Streams the 16 entries out one per beat in row-major order over a valid/ready handshake, tagging each beat with row, column and last.
- Feeds display/UART formatting logic downstream; it decouples the multiply path from a slow consumer.

Parameters:
- ENTRY_W, 6, width of one result entry (max 4 * 3 * 3 = 36 fits in 6 bits)
- N, 4, matrix dimension; entry count = N*N; packed input width = N*N*ENTRY_W

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- mat_in  input  N*N*ENTRY_W (96)  packed product; C[0][0] at [95:90], C[0][1] at [89:84], ..., C[3][3] at [5:0]
- finish  input  1  multiply path done; level, held high until that path is reset
- out_data  output  ENTRY_W  current entry
- out_row  output  2  row index of out_data
- out_col  output  2  column index of out_data
- out_last  output  1  high on the beat carrying C[3][3]
- out_valid  output  1  beat valid
- out_ready  input  1  consumer accepts beat
- busy  output  1  high while captured data is being streamed
- done  output  1  one-cycle pulse after the final beat transfers

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, index=0, capture register=0.
  - out_valid=0, out_last=0, busy=0, done=0, out_data/out_row/out_col=0.
- States: IDLE, SEND, WAIT_CLR.
- IDLE:
  - On a cycle where finish=1: capture mat_in into an internal 96-bit register, index<=0, go to SEND.
  - out_valid rises on the next cycle. Latency finish->first out_valid = 1 cycle.
- SEND:
  - out_valid=1, busy=1.
  - out_data = captured entry[index], where entry k occupies bits [95-6k : 90-6k].
  - out_row=index[3:2], out_col=index[1:0], out_last=(index==15).
  - Transfer occurs when out_valid && out_ready on a rising edge. On transfer with index<15: index<=index+1.
  - On transfer with index==15: go to WAIT_CLR, done=1 for exactly the next cycle, out_valid=0.
  - out_ready=0: all outputs hold stable; no beat is dropped or repeated.
  - out_ready held high: 16 beats on 16 consecutive cycles.
- WAIT_CLR:
  - out_valid=0, busy=0.
  - Remain until finish=0, then go to IDLE.
  - Guarantees one stream per multiply, because finish is a held level.
- mat_in changes after capture have no effect on the stream in progress.
- finish dropping during SEND is ignored; the stream completes. On completion, WAIT_CLR exits on the next cycle if finish is already 0.
- index is 4 bits and never wraps past 15 within a stream.
- Reset asserted mid-stream:
  - Immediate return to IDLE with outputs cleared and no done pulse.
  - After release with finish still high, a fresh capture and full 16-beat stream begins.
- out_data is registered (driven from the capture register via registered index). No combinational path from out_ready to out_valid.

Optional Feature:
- Macro: RESULT_CHECKSUM_EN.
- When defined:
  - Adds output port chk_out, width 10, plus the checksum accumulator register.
  - chk_out = unsigned sum of all 16 transferred entries (max 576).
  - Accumulates on each transfer, cleared at capture and on reset.
  - Valid and stable from the done cycle until the next capture.
- When undefined: port and accumulator absent; all other behaviour identical.

Test Plan:
- Entries k=0..15 packed (C[i][j]=4i+j), finish=1, out_ready=1 -> out_valid rises 1 cycle after finish.
  - out_data 0,1,...,15 on 16 consecutive cycles; row/col (0,0)..(3,3).
  - out_last only on value 15; done pulses once the following cycle; busy low afterwards.
- Same data, out_ready toggling 1,0,0,1,... -> each value appears exactly once in order; out_data/row/col stable during every stall; total 16 transfers.
- finish held high for 60 cycles after the stream -> exactly one stream (16 beats). Then finish=0 for 1 cycle, then finish=1 with all entries 36 -> a second stream of sixteen 36s.
- Change mat_in to all-zero on the cycle after capture -> stream still emits the captured 0..15 values.
- Assert rst during beat 7 (value 7) -> out_valid, busy, done drop immediately. Release with finish=1 -> stream restarts at value 0 with row/col (0,0).
- RESULT_CHECKSUM_EN defined, all entries 36 -> chk_out=576 at done. With entries 0..15 -> chk_out=120.
